id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the RV32IM core, directly upstream of the ALU. It registers the decoded instruction each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It selects the final ALU operands `data1`/`data2` and drives `ALU_op`. It detects load-use hazards, raises a stall toward IF/ID and inserts a bubble, and supports flush (taken branch/jump) and hold (downstream multi-cycle busy).

## Interface
- No parameters; XLEN fixed at 32, register index 5 bits, ALU_op 4 bits (ALU encoding: ADD=0 … MULHU=14).
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — synchronous, active-low reset; one clock, all state sampled on `clk`.
- `id_valid` in 1 — ID holds a valid instruction.
- `id_pc` in 32 — instruction PC.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5 each — register indices.
- `id_rs1_data`, `id_rs2_data` in 32 each — register-file read data.
- `id_imm` in 32 — sign-extended/shifted immediate.
- `id_use_rs1`, `id_use_rs2` in 1 each — instruction reads rs1/rs2.
- `id_ALU_op` in 4 — ALU operation.
- `id_src1_sel` in 2 — 0 = rs1, 1 = PC, 2 = zero, 3 = reserved (zero).
- `id_src2_sel` in 1 — 0 = rs2, 1 = imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1 each — control.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32 — EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_data` in 32 — MEM/WB forward source.
- `flush` in 1 — kill the instruction entering EX.
- `ex_hold` in 1 — freeze the stage.
- `load_use_stall` out 1 — upstream must hold PC and IF/ID.
- `data1`, `data2` out 32 — ALU operands.
- `ALU_op` out 4 — registered op.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1 each.
- `ex_rd` out 5.
- `ex_pc` out 32.
- `ex_store_data` out 32 — forwarded rs2 value.

## Operation
- The registered state holds every `id_*` field plus its `ex_*` counterpart.
- Register update priority, evaluated each rising edge:
  1. `!rst_n`: clear all.
  2. `ex_hold`: keep all.
  3. `flush`: bubble.
  4. `load_use_stall`: bubble.
  5. Otherwise capture ID, with `ex_valid <= id_valid`.
- Bubble: all registered fields become 0. That gives `ex_valid=0`, `ex_reg_write=0`, `ex_mem_read=0`, `ex_mem_write=0`, `ALU_op=0` (ADD), `ex_rd=0`.
- `flush` is ignored while `ex_hold=1`; the requester keeps it asserted until hold drops.
- Forwarding (combinational, applied per source `s` ∈ {rs1, rs2} using the registered address):
  - If `exmem_reg_write && exmem_rd!=0 && exmem_rd==ex_s`, use `exmem_result`.
  - Else if `memwb_reg_write && memwb_rd!=0 && memwb_rd==ex_s`, use `memwb_data`.
  - Else use the registered register-file data.
  - EX/MEM takes priority over MEM/WB. x0 is never forwarded.
- Operand select:
  - `data1` = fwd_rs1 / `ex_pc` / 0 / 0 for `src1_sel` = 0 / 1 / 2 / 3.
  - `data2` = fwd_rs2 when `src2_sel=0`, registered imm when 1.
  - `ex_store_data` = fwd_rs2 always.
- Load-use detection:
  - `load_use_stall = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && ((id_use_rs1 && id_rs1_addr==ex_rd) || (id_use_rs2 && id_rs2_addr==ex_rd))`.
  - Forced 0 while `ex_hold=1` or `flush=1`.

## Timing
- Reset values: every output is 0. The only exception is `data1`/`data2`, which follow the forwarding inputs. With reset state `ex_rs*=0`, no forward can match, so both read 0.
- Latency:
  - ID inputs appear on `ex_*` / `ALU_op` one cycle after the capturing edge.
  - `data1`/`data2` are combinational from registered state plus same-cycle forward inputs, with zero extra cycles.
- Load-use:
  - Stall is asserted for exactly one cycle per hazard; a bubble enters EX.
  - Next cycle the load sits in MEM and the dependent instruction is captured. Its operand is forwarded from MEM/WB one cycle later, when the consumer is in EX.
- Hold: state is frozen indefinitely. The outputs stay stable except for changes in the forward inputs.
- Simultaneous flush and load_use_stall: flush wins (bubble), and the stall output is 0.
- Reset mid-hold or mid-stall: reset dominates and clears everything next edge.

## Test plan
- Reset: drive `rst_n=0` for 2 cycles with arbitrary ID inputs → all outputs 0; `ALU_op=0`, `ex_valid=0`.
- Basic capture: `id_rs1_data=5`, `id_imm=7`, `src2_sel=1`, `ALU_op=0` → next cycle `data1=5`, `data2=7`, `ex_valid=1`.
- Forward priority: `ex_rs1=3`, with `exmem_rd=3`/`result=0xAA` and `memwb_rd=3`/`data=0xBB` both writing → `data1=0xAA`. Drop `exmem_reg_write` → `data1=0xBB`. Set `ex_rs1=0` with matching rd=0 → no forward.
- Load-use: `lw x5` in EX, ID `add x6,x5,x1` with `use_rs1=1` → `load_use_stall=1` for one cycle, next `ex_valid=0`, then the add is captured. A reader of x0 behind a load to x0 → no stall.
- Flush vs stall: assert a load-use condition and `flush` together → stall=0, bubble captured. `flush` during `ex_hold` → registers unchanged.
- Hold: `ex_hold=1` for 3 cycles while ID changes → `ALU_op`, `ex_rd`, `ex_pc` unchanged. On release, the current ID is captured.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- signal bundle between the decode stage, the forwarding
// sources and the ID/EX pipeline register.
//   ID side      : id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
//                  id_rs1_data, id_rs2_data, id_imm, id_use_rs1, id_use_rs2,
//                  id_ALU_op, id_src1_sel, id_src2_sel, id_reg_write,
//                  id_mem_read, id_mem_write
//   Forwarding   : exmem_reg_write/rd/result, memwb_reg_write/rd/data
//   Control      : flush, ex_hold
//   EX side      : load_use_stall, data1, data2, ALU_op, ex_valid,
//                  ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc,
//                  ex_store_data
// The slave modport is the pipeline stage; master is whoever drives ID.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [3:0]  id_ALU_op;
  logic [1:0]  id_src1_sel;
  logic        id_src2_sel;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        flush;
  logic        ex_hold;
  logic        load_use_stall;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  ALU_op;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc;
  logic [31:0] ex_store_data;

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imm, id_use_rs1, id_use_rs2,
           id_ALU_op, id_src1_sel, id_src2_sel, id_reg_write,
           id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
           flush, ex_hold,
    output load_use_stall, data1, data2, ALU_op, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_rd, ex_pc, ex_store_data
  );

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imm, id_use_rs1, id_use_rs2,
           id_ALU_op, id_src1_sel, id_src2_sel, id_reg_write,
           id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
           flush, ex_hold,
    input  load_use_stall, data1, data2, ALU_op, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_rd, ex_pc, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the RV32IM core.
// Registers the decoded instruction, forwards results from EX/MEM and MEM/WB
// into the ALU operands, detects load-use hazards (stall + bubble) and
// supports flush and hold.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : id_ex_stage_if.slave (ID inputs, forward sources, control,
//           EX-side outputs)
module id_ex_stage (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  // The use_rs flags are only needed for hazard detection on the ID side,
  // so they are not carried into EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_state_t;

  ex_state_t   state_q;
  ex_state_t   state_d;
  logic        stall_raw;
  logic        stall;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // Closest producer wins; x0 always reads as the register-file value.
  function automatic logic [31:0] forward(
    input logic [4:0]  src,
    input logic [31:0] rf_data,
    input logic        xm_we,
    input logic [4:0]  xm_rd,
    input logic [31:0] xm_val,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_val
  );
    if (xm_we && (xm_rd != 5'd0) && (xm_rd == src))
      return xm_val;
    else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src))
      return mw_val;
    else
      return rf_data;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    stall_raw = state_q.valid && state_q.mem_read && (state_q.rd_addr != 5'd0)
              && bus.id_valid
              && ((bus.id_use_rs1 && (bus.id_rs1_addr == state_q.rd_addr))
               || (bus.id_use_rs2 && (bus.id_rs2_addr == state_q.rd_addr)));
    // A held stage cannot accept the bubble, and a flush already kills ID.
    stall = stall_raw && !bus.ex_hold && !bus.flush;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.ex_hold) begin
      if (bus.flush || stall) begin
        state_d = '0;
      end else begin
        state_d.valid     = bus.id_valid;
        state_d.pc        = bus.id_pc;
        state_d.rs1_addr  = bus.id_rs1_addr;
        state_d.rs2_addr  = bus.id_rs2_addr;
        state_d.rd_addr   = bus.id_rd_addr;
        state_d.rs1_data  = bus.id_rs1_data;
        state_d.rs2_data  = bus.id_rs2_data;
        state_d.imm       = bus.id_imm;
        state_d.alu_op    = bus.id_ALU_op;
        state_d.src1_sel  = bus.id_src1_sel;
        state_d.src2_sel  = bus.id_src2_sel;
        state_d.reg_write = bus.id_reg_write;
        state_d.mem_read  = bus.id_mem_read;
        state_d.mem_write = bus.id_mem_write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  always_comb begin
    fwd_rs1 = forward(state_q.rs1_addr, state_q.rs1_data,
                      bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                      bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
    fwd_rs2 = forward(state_q.rs2_addr, state_q.rs2_data,
                      bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                      bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
  end

  always_comb begin
    unique case (state_q.src1_sel)
      2'd0:    bus.data1 = fwd_rs1;
      2'd1:    bus.data1 = state_q.pc;
      default: bus.data1 = 32'd0;
    endcase
    bus.data2 = state_q.src2_sel ? state_q.imm : fwd_rs2;
  end

  assign bus.ex_store_data  = fwd_rs2;
  assign bus.load_use_stall = stall;
  assign bus.ALU_op         = state_q.alu_op;
  assign bus.ex_valid       = state_q.valid;
  assign bus.ex_reg_write   = state_q.reg_write;
  assign bus.ex_mem_read    = state_q.mem_read;
  assign bus.ex_mem_write   = state_q.mem_write;
  assign bus.ex_rd          = state_q.rd_addr;
  assign bus.ex_pc          = state_q.pc;

endmodule
